// File: rtl/parallel_adder.sv
// Ripple-carry adder built from a chain of 1-bit full-adder stages.
// Sum, per-stage carries and signed overflow are registered with a valid qualifier.
module parallel_adder #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] s,
  input  logic             ci,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] co,
  output logic             ovf,
  output logic             out_valid
);

  logic [WIDTH-1:0] c_in;
  logic [WIDTH-1:0] sum_d;
  logic [WIDTH-1:0] co_d;
  logic             ovf_d;

  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] co_q;
  logic             ovf_q;
  logic             valid_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    if (i == 0) begin : g_first
      assign c_in[i] = ci;
    end else begin : g_chain
      assign c_in[i] = co_d[i-1];
    end

    assign sum_d[i] = r[i] ^ s[i] ^ c_in[i];
    assign co_d[i]  = (r[i] & s[i]) | (r[i] & c_in[i]) | (s[i] & c_in[i]);
  end

  // A single-bit adder has no sign boundary to cross.
  if (WIDTH > 1) begin : g_ovf
    assign ovf_d = co_d[WIDTH-1] ^ co_d[WIDTH-2];
  end else begin : g_no_ovf
    assign ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q   <= '0;
      co_q    <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        sum_q <= sum_d;
        co_q  <= co_d;
        ovf_q <= ovf_d;
      end
    end
  end

  assign out       = sum_q;
  assign co        = co_q;
  assign ovf       = ovf_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_parallel_adder.sv
// Directed and exhaustive checks of the registered 4-bit ripple-carry adder.
module tb_parallel_adder;

  localparam int unsigned WIDTH = 4;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] s;
  logic             ci;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] co;
  logic             ovf;
  logic             out_valid;

  int checks;
  int errors;

  parallel_adder #(
    .WIDTH(WIDTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .r        (r),
    .s        (s),
    .ci       (ci),
    .out      (out),
    .co       (co),
    .ovf      (ovf),
    .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] e_out, input logic [3:0] e_co,
                           input logic e_ovf, input logic e_valid);
    check({tag, ".out"}, 32'(out), 32'(e_out));
    check({tag, ".co"}, 32'(co), 32'(e_co));
    check({tag, ".ovf"}, 32'(ovf), 32'(e_ovf));
    check({tag, ".valid"}, 32'(out_valid), 32'(e_valid));
  endtask

  initial begin
    logic [4:0] full;
    logic [3:0] ref_co;
    logic [4:0] part;

    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    in_valid = 1'b1;
    r        = 4'hF;
    s        = 4'hF;
    ci       = 1'b1;

    // Reset wins over in_valid for two cycles, then one idle cycle.
    step();
    check_all("reset0", 4'h0, 4'h0, 1'b0, 1'b0);
    step();
    check_all("reset1", 4'h0, 4'h0, 1'b0, 1'b0);
    rst      = 1'b0;
    in_valid = 1'b0;
    step();
    check_all("reset_after", 4'h0, 4'h0, 1'b0, 1'b0);

    in_valid = 1'b1; r = 4'b0010; s = 4'b0001; ci = 1'b0;
    step();
    check_all("basic", 4'b0011, 4'b0000, 1'b0, 1'b1);

    r = 4'b1111; s = 4'b0000; ci = 1'b1;
    step();
    check_all("ripple", 4'b0000, 4'b1111, 1'b0, 1'b1);

    r = 4'b0111; s = 4'b0001; ci = 1'b0;
    step();
    check_all("ovf_pos", 4'b1000, 4'b0111, 1'b1, 1'b1);

    r = 4'b1000; s = 4'b1000; ci = 1'b0;
    step();
    check_all("ovf_neg", 4'b0000, 4'b1000, 1'b1, 1'b1);

    r = 4'd3; s = 4'd4; ci = 1'b0;
    step();
    check_all("hold_load", 4'b0111, 4'b0000, 1'b0, 1'b1);
    in_valid = 1'b0; r = 4'd9; s = 4'd9;
    step();
    check_all("hold0", 4'b0111, 4'b0000, 1'b0, 1'b0);
    step();
    check_all("hold1", 4'b0111, 4'b0000, 1'b0, 1'b0);

    // Operand presented alongside reset is dropped.
    rst = 1'b1; in_valid = 1'b1; r = 4'd5; s = 4'd5;
    step();
    check_all("mid_rst", 4'h0, 4'h0, 1'b0, 1'b0);
    rst = 1'b0; in_valid = 1'b0;
    step();
    check_all("mid_rst_after", 4'h0, 4'h0, 1'b0, 1'b0);

    // Every (r, s, ci) streamed back-to-back.
    in_valid = 1'b1;
    for (int i = 0; i < 512; i++) begin
      r  = i[3:0];
      s  = i[7:4];
      ci = i[8];
      full = 5'(r) + 5'(s) + 5'(ci);
      for (int b = 0; b < 4; b++) begin
        part      = 5'((r & 4'((1 << (b + 1)) - 1))) + 5'((s & 4'((1 << (b + 1)) - 1))) + 5'(ci);
        ref_co[b] = part[b+1];
      end
      step();
      check_all($sformatf("exh_%0d", i), full[3:0], ref_co, ref_co[3] ^ ref_co[2], 1'b1);
      check($sformatf("exh_%0d.carry", i), 32'(co[3]), 32'(full[4]));
    end

    in_valid = 1'b0; r = 4'h0; s = 4'h0; ci = 1'b0;
    step();
    check_all("stream_end", 4'hF, 4'hF, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/parallel_adder.md
Name: parallel_adder

Overview:
- Parameterised ripple-carry parallel adder built from a chain of 1-bit full-adder stages.
- Adds operands r and s plus carry-in ci.
- Exposes the sum and the carry-out of every stage.
- Results are registered: one-cycle latency, with a valid qualifier.
- Used as a generic arithmetic leaf in datapaths that need per-bit carry visibility, e.g. BCD correction or carry-chain debug.

Parameters:
- WIDTH, 4, operand/sum width in bits; must be >= 1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands valid; sampled on rising clk
- r  input  WIDTH  operand A, unsigned or two's complement
- s  input  WIDTH  operand B
- ci  input  1  carry-in to stage 0
- out  output  WIDTH  registered sum bits
- co  output  WIDTH  registered carry-out of each stage; co[WIDTH-1] is the final carry
- ovf  output  1  registered signed overflow, co[WIDTH-1] XOR co[WIDTH-2]; equals 0 when WIDTH=1
- out_valid  output  1  registered; high the cycle after an accepted in_valid

Behaviour:
- Stage i (0..WIDTH-1) is a full adder with carry-in c_i. c_0 = ci and c_{i+1} = co_comb[i].
  - sum_i = r[i] ^ s[i] ^ c_i
  - co_comb[i] = (r[i]&s[i]) | (r[i]&c_i) | (s[i]&c_i)
- The chain is purely combinational between the input ports and the output registers. No input registers.
- Rising clk with rst=1:
  - out, co and ovf are set to 0 and out_valid to 0.
  - rst has priority over in_valid.
- Rising clk with rst=0 and in_valid=1:
  - out and co load the combinational results, ovf loads its value.
  - out_valid is set to 1.
  - Latency is exactly 1 cycle.
- Rising clk with rst=0 and in_valid=0:
  - out, co and ovf hold their previous values.
  - out_valid is set to 0.
- No backpressure. A new operand set may be accepted every cycle (throughput 1/cycle).
- Arithmetic identity: {co[WIDTH-1], out} == r + s + ci, computed as a (WIDTH+1)-bit unsigned result.
- Wrap-around: the sum is modulo 2^WIDTH and the carry is reported in co[WIDTH-1]. Example: all-ones + 1 gives out=0 and every co bit = 1.
- Reset mid-stream: an operand presented in the same cycle as rst is discarded. out_valid stays 0 the following cycle.
- Inputs are not required to be stable when in_valid=0. Outputs must not change in that case.
- Outputs are glitch-free, driven only from flops.

Test Plan:
- Reset: assert rst for 2 cycles with in_valid=1, r=4'hF, s=4'hF → out=0, co=0, ovf=0, out_valid=0 throughout and the cycle after.
- Basic add: r=4'b0010, s=4'b0001, ci=0, in_valid=1 → next cycle out=4'b0011, co=4'b0000, ovf=0, out_valid=1.
- Ripple carry: r=4'b1111, s=4'b0000, ci=1 → out=4'b0000, co=4'b1111, ovf=0.
- Signed overflow: r=4'b0111, s=4'b0001, ci=0 → out=4'b1000, co=4'b0111, ovf=1. Also r=4'b1000, s=4'b1000 → out=0, co=4'b1000, ovf=1.
- Hold/valid: apply r=3, s=4, in_valid=1 for one cycle, then in_valid=0 with r=9, s=9 → out stays 4'b0111, out_valid 1 then 0.
- Back-to-back and exhaustive: all 512 (r, s, ci) combinations streamed with in_valid=1 → each result matches r+s+ci one cycle later, and co matches a reference full-adder chain.
